// File: rtl/proc_pkg.sv
// Shared types and constants for the frame processing sequencer and its timeout counter.
package proc_pkg;

   localparam int PIX_W_DEF  = 24;
   localparam int ADDR_W_DEF = 18;

   localparam logic [2:0] S_IDLE_ENC     = 3'd0;
   localparam logic [2:0] S_RD_ISSUE_ENC = 3'd1;
   localparam logic [2:0] S_RD_WAIT_ENC  = 3'd2;
   localparam logic [2:0] S_REQ_ENC      = 3'd3;
   localparam logic [2:0] S_ACK_LOW_ENC  = 3'd4;
   localparam logic [2:0] S_WRITE_ENC    = 3'd5;
   localparam logic [2:0] S_NEXT_ENC     = 3'd6;
   localparam logic [2:0] S_DONE_ENC     = 3'd7;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE_ENC,
      ST_RD_ISSUE = S_RD_ISSUE_ENC,
      ST_RD_WAIT  = S_RD_WAIT_ENC,
      ST_REQ      = S_REQ_ENC,
      ST_ACK_LOW  = S_ACK_LOW_ENC,
      ST_WRITE    = S_WRITE_ENC,
      ST_NEXT     = S_NEXT_ENC,
      ST_DONE     = S_DONE_ENC
   } state_t;

   localparam logic [2:0] OP_COPY     = 3'b000;
   localparam logic [2:0] OP_BRIGHTEN = 3'b001;
   localparam logic [2:0] OP_DARKEN   = 3'b010;
   localparam logic [2:0] OP_THRESH   = 3'b011;
   localparam logic [2:0] OP_GRAY     = 3'b100;
   localparam logic [2:0] OP_INVERT   = 3'b111;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

endpackage

// File: rtl/seq_timeout_ctr.sv
// Saturating wait counter: clr restarts it, en advances it, expire flags the TIMEOUT-th enabled cycle.
// Single cycle, no backpressure; expire is combinational from the count register.
module seq_timeout_ctr
   import proc_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && cnt_q != LAST) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/frame_process_sequencer.sv
// Walks a frame: read source BRAM, four-phase OKin/OKout handshake with `process`, write result.
// Per pixel 3 + RD_LAT cycles plus handshake time; each handshake phase aborts after TIMEOUT cycles.
module frame_process_sequencer
   import proc_pkg::*;
#(
   parameter int NUM_PIXELS = 200000,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int PIX_W      = PIX_W_DEF,
   parameter int RD_LAT     = 1,
   parameter int TIMEOUT    = 1023
) (
   input  logic              clka,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [2:0]        op_in,
   input  logic [7:0]        value_in,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic              src_ena,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [PIX_W-1:0]  src_dout,
   output logic [7:0]        Rin,
   output logic [7:0]        Gin,
   output logic [7:0]        Bin,
   output logic [2:0]        operation,
   output logic [7:0]        value,
   output logic              OKin,
   input  logic              OKout,
   input  logic [7:0]        Rout,
   input  logic [7:0]        Gout,
   input  logic [7:0]        Bout,
   output logic              dst_wea,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [PIX_W-1:0]  dst_din
);

   localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [1:0]        RD_LAST  = 2'(RD_LAT - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [1:0]          rd_cnt_q, rd_cnt_d;
   logic                armed_q, armed_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic                src_ena_q, src_ena_d;
   logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
   pix_t                rgb_in_q, rgb_in_d;
   logic [2:0]          op_q, op_d;
   logic [7:0]          val_q, val_d;
   logic                okin_q, okin_d;
   logic                wea_q, wea_d;
   logic [ADDR_W-1:0]   dst_addr_q, dst_addr_d;
   pix_t                res_q, res_d;
   logic                tmo_en, tmo_clr, tmo_expire;

   assign tmo_en  = (state_q == ST_REQ) || (state_q == ST_ACK_LOW);
   assign tmo_clr = (state_d != state_q);

   seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk(clka), .rst_n(reset), .clr(tmo_clr), .en(tmo_en), .expire(tmo_expire)
   );

   always_comb begin
      state_d = state_q;   cnt_d = cnt_q;       rd_cnt_d = rd_cnt_q;  armed_d = armed_q;
      busy_d = busy_q;     done_d = 1'b0;       error_d = error_q;    src_ena_d = 1'b0;
      src_addr_d = src_addr_q;  rgb_in_d = rgb_in_q;  op_d = op_q;    val_d = val_q;
      okin_d = okin_q;     wea_d = 1'b0;        dst_addr_d = dst_addr_q;  res_d = res_q;
      case (state_q)
         ST_IDLE: if (start && !abort) begin
            op_d = op_in;  val_d = value_in;  error_d = 1'b0;  cnt_d = '0;  busy_d = 1'b1;
            src_ena_d = 1'b1;  src_addr_d = '0;  state_d = ST_RD_ISSUE;
         end
         ST_RD_ISSUE: begin
            rd_cnt_d = '0;
            state_d  = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (rd_cnt_q == RD_LAST) begin
            // A still-high acknowledge from the previous pixel must fall before OKin rises.
            rgb_in_d = pix_t'(src_dout);  okin_d = !OKout;  armed_d = !OKout;  state_d = ST_REQ;
         end else begin
            rd_cnt_d = rd_cnt_q + 2'd1;
         end
         ST_REQ: if (!armed_q) begin
            if (!OKout) begin
               armed_d = 1'b1;
               okin_d  = 1'b1;
            end
         end else if (OKout) begin
            res_d = '{r: Rout, g: Gout, b: Bout};  okin_d = 1'b0;  state_d = ST_ACK_LOW;
         end
         ST_ACK_LOW: if (!OKout) begin
            wea_d = 1'b1;  dst_addr_d = cnt_q;  state_d = ST_WRITE;
         end
         ST_WRITE: state_d = ST_NEXT;
         ST_NEXT: if (cnt_q == LAST_PIX) begin
            done_d = 1'b1;  busy_d = 1'b0;  state_d = ST_DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;  src_ena_d = 1'b1;  src_addr_d = cnt_q + 1'b1;  state_d = ST_RD_ISSUE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // A handshake that completes on the last allowed cycle is not a timeout.
      if (tmo_expire && state_d == state_q) begin
         error_d = 1'b1;  okin_d = 1'b0;  busy_d = 1'b0;  state_d = ST_IDLE;
      end
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;  okin_d = 1'b0;  wea_d = 1'b0;  busy_d = 1'b0;
         src_ena_d = 1'b0;  done_d = 1'b0;  error_d = error_q;
      end
   end

   always_ff @(posedge clka or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;  cnt_q <= '0;     rd_cnt_q <= '0;   armed_q <= 1'b0;
         busy_q <= 1'b0;      done_q <= 1'b0;  error_q <= 1'b0;  src_ena_q <= 1'b0;
         src_addr_q <= '0;    rgb_in_q <= '0;  op_q <= '0;       val_q <= '0;
         okin_q <= 1'b0;      wea_q <= 1'b0;   dst_addr_q <= '0; res_q <= '0;
      end else begin
         state_q <= state_d;  cnt_q <= cnt_d;   rd_cnt_q <= rd_cnt_d;  armed_q <= armed_d;
         busy_q <= busy_d;    done_q <= done_d; error_q <= error_d;    src_ena_q <= src_ena_d;
         src_addr_q <= src_addr_d;  rgb_in_q <= rgb_in_d;  op_q <= op_d;  val_q <= val_d;
         okin_q <= okin_d;    wea_q <= wea_d;   dst_addr_q <= dst_addr_d;  res_q <= res_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign src_ena   = src_ena_q;
   assign src_addr  = src_addr_q;
   assign Rin       = rgb_in_q.r;
   assign Gin       = rgb_in_q.g;
   assign Bin       = rgb_in_q.b;
   assign operation = op_q;
   assign value     = val_q;
   assign OKin      = okin_q;
   assign dst_wea   = wea_q;
   assign dst_addr  = dst_addr_q;
   assign dst_din   = res_q;

endmodule

// File: tb/tb_frame_process_sequencer.sv
// Directed bench: behavioural source BRAM, random-delay `process` model, write/done monitor.
module tb_frame_process_sequencer;
   import proc_pkg::*;

   localparam int NPIX = 16;
   localparam int TMO  = 50;
   localparam int AW   = 18;

   logic clka = 1'b0;
   logic reset, start, abort, OKout, src_ena, busy, done, error, OKin, dst_wea;
   logic [2:0] op_in, operation;
   logic [7:0] value_in, value, Rin, Gin, Bin, Rout, Gout, Bout;
   logic [AW-1:0] src_addr, dst_addr;
   logic [23:0] src_dout = '0, dst_din;
   logic [100:0] all_out;

   int checks = 0, failures = 0;
   int mdl_mode = 0;             // 0 random ack, 1 never ack, 2 manual
   logic man_ok = 1'b0;
   logic [23:0] man_pix = '0;
   logic [2:0] cur_op = '0;
   logic [AW-1:0] wr_addr[$];
   logic [23:0] wr_din[$];
   int done_cnt = 0, done_busy_bad = 0, op_bad = 0, wea_long = 0;
   logic prev_wea = 1'b0, prev_busy = 1'b0;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  val;
      bit          poke;
      int          idx;
      logic [23:0] exp_din;
   } vec_t;
   vec_t vecs[3];

   always #5 clka = ~clka;

   frame_process_sequencer #(.NUM_PIXELS(NPIX), .ADDR_W(AW), .PIX_W(24), .RD_LAT(1), .TIMEOUT(TMO)) dut (
      .clka(clka), .reset(reset), .start(start), .abort(abort), .op_in(op_in), .value_in(value_in),
      .busy(busy), .done(done), .error(error), .src_ena(src_ena), .src_addr(src_addr),
      .src_dout(src_dout), .Rin(Rin), .Gin(Gin), .Bin(Bin), .operation(operation), .value(value),
      .OKin(OKin), .OKout(OKout), .Rout(Rout), .Gout(Gout), .Bout(Bout),
      .dst_wea(dst_wea), .dst_addr(dst_addr), .dst_din(dst_din)
   );

   assign all_out = {busy, done, error, src_ena, src_addr, Rin, Gin, Bin, operation, value,
                     OKin, dst_wea, dst_addr, dst_din};

   function automatic logic [23:0] pix_of(input logic [AW-1:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {b, ~b, 8'h55};
   endfunction

   function automatic logic [23:0] proc_fn(input logic [23:0] p, input logic [2:0] op, input logic [7:0] v);
      return ~p ^ {v, v, v} ^ {21'd0, op};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clka) if (src_ena) src_dout <= pix_of(src_addr);

   initial begin : process_model
      int d;
      OKout = 1'b0;
      {Rout, Gout, Bout} = '0;
      forever begin
         @(posedge clka); #1;
         if (mdl_mode == 2) begin
            OKout = man_ok;
            {Rout, Gout, Bout} = man_pix;
         end else if (mdl_mode == 1) begin
            OKout = 1'b0;
         end else if (OKin && !OKout) begin
            d = $urandom_range(4, 1);
            repeat (d) @(posedge clka);
            #1;
            {Rout, Gout, Bout} = proc_fn({Rin, Gin, Bin}, operation, value);
            OKout = 1'b1;
            do begin @(posedge clka); #1; end while (OKin);
            OKout = 1'b0;
         end
      end
   end

   always @(negedge clka) begin
      if (reset) begin
         if (dst_wea) begin
            wr_addr.push_back(dst_addr);
            wr_din.push_back(dst_din);
            if (prev_wea) wea_long++;
         end
         if (done) begin
            done_cnt++;
            if (busy || !prev_busy) done_busy_bad++;
         end
         if (busy && operation != cur_op) op_bad++;
      end
      prev_wea  = dst_wea;
      prev_busy = busy;
   end

   task automatic pulse_start(input logic [2:0] op, input logic [7:0] val);
      @(negedge clka);
      cur_op = op; op_in = op; value_in = val; start = 1'b1;
      @(negedge clka);
      start = 1'b0; op_in = '0; value_in = '0;
   endtask

   task automatic run_pass(input logic [2:0] op, input logic [7:0] val, input bit poke,
                           input int idx, input logic [23:0] exp_din);
      int wb, db, ob, dbb, wl, n, bad;
      logic [23:0] got;
      wb = wr_addr.size(); db = done_cnt; ob = op_bad; dbb = done_busy_bad; wl = wea_long;
      pulse_start(op, val);
      chk("pass_busy_after_start", busy, 1);
      if (poke) begin
         start = 1'b1; op_in = OP_BRIGHTEN; value_in = 8'hAA;
         @(negedge clka);
         start = 1'b0; op_in = '0; value_in = '0;
      end
      n = 0;
      while (!done && n < 3000) begin @(negedge clka); n++; end
      chk("pass_done_seen", done, 1);
      repeat (4) @(negedge clka);
      chk("pass_done_once", done_cnt - db, 1);
      chk("pass_write_count", wr_addr.size() - wb, NPIX);
      bad = 0;
      for (int i = 0; i < NPIX && wb + i < wr_addr.size(); i++)
         if (wr_addr[wb+i] != AW'(i) || wr_din[wb+i] != proc_fn(pix_of(AW'(i)), op, val)) bad++;
      chk("pass_write_addr_data", bad, 0);
      got = (wr_din.size() > wb + idx) ? wr_din[wb+idx] : 24'h0;
      chk("pass_table_din", got, exp_din);
      chk("pass_done_with_busy_drop", done_busy_bad - dbb, 0);
      chk("pass_op_stable", op_bad - ob, 0);
      chk("pass_op_held_idle", operation, op);
      chk("pass_value_held_idle", value, val);
      chk("pass_wea_single_cycle", wea_long - wl, 0);
      chk("pass_idle_busy", busy, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int wb, db, n, k;
      logic [23:0] got;
      bit prev_okin;
      vecs[0] = '{3'b111, 8'h00, 1'b1, 0,  24'hFF00AD};
      vecs[1] = '{3'b010, 8'h0F, 1'b0, 5,  24'hF50AA7};
      vecs[2] = '{3'b000, 8'hFF, 1'b0, 15, 24'h0FF055};
      reset = 1'b1; start = 1'b0; abort = 1'b0; op_in = '0; value_in = '0;
      #3 reset = 1'b0;
      #4 chk("reset_outputs_zero_bits", $countones(all_out), 0);
      repeat (2) @(negedge clka);
      reset = 1'b1;
      repeat (2) @(negedge clka);

      for (int v = 0; v < 3; v++)
         run_pass(vecs[v].op, vecs[v].val, vecs[v].poke, vecs[v].idx, vecs[v].exp_din);

      // Asynchronous reset while requesting pixel 5, then a clean restart.
      wb = wr_addr.size();
      pulse_start(3'b101, 8'h22);
      n = 0;
      while (!(wr_addr.size() - wb == 5 && OKin) && n < 1000) begin @(negedge clka); n++; end
      chk("rst_mid_reached_px5", wr_addr.size() - wb, 5);
      #2 reset = 1'b0;
      #1 chk("rst_mid_outputs_zero_bits", $countones(all_out), 0);
      repeat (10) @(negedge clka);
      reset = 1'b1;
      run_pass(3'b011, 8'h10, 1'b0, 0, 24'hEF10B9);

      // Start and abort together in IDLE: start is dropped.
      @(negedge clka);
      start = 1'b1; abort = 1'b1; op_in = 3'b110;
      @(negedge clka);
      start = 1'b0; abort = 1'b0; op_in = '0;
      chk("abort_beats_start_busy", busy, 0);
      chk("abort_beats_start_op", operation, 3'b011);

      // Abort in the first ACK_LOW cycle of pixel 7.
      wb = wr_addr.size(); db = done_cnt;
      pulse_start(3'b100, 8'h33);
      n = 0; prev_okin = 1'b0;
      while (!(wr_addr.size() - wb == 7 && prev_okin && !OKin) && n < 1000) begin
         prev_okin = OKin;
         @(negedge clka); n++;
      end
      chk("abort_reached_px7", wr_addr.size() - wb, 7);
      abort = 1'b1;
      @(negedge clka);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_okin", OKin, 0);
      chk("abort_wea", dst_wea, 0);
      repeat (20) @(negedge clka);
      chk("abort_no_more_writes", wr_addr.size() - wb, 7);
      chk("abort_no_done", done_cnt - db, 0);
      chk("abort_no_error", error, 0);

      // Handshake timeout: process never acknowledges.
      mdl_mode = 1; db = done_cnt;
      pulse_start(3'b111, 8'h01);
      n = 0;
      while (!OKin && n < 20) begin @(negedge clka); n++; end
      chk("tmo_req_entered", OKin, 1);
      k = 0;
      while (!error && k < 3 * TMO) begin @(negedge clka); k++; end
      chk("tmo_cycles_to_error", k, TMO);
      chk("tmo_okin", OKin, 0);
      chk("tmo_busy", busy, 0);
      repeat (5) @(negedge clka);
      chk("tmo_error_sticky", error, 1);
      chk("tmo_no_done", done_cnt - db, 0);

      // Stale acknowledge held across REQ entry.
      man_pix = 24'hDEADBE; man_ok = 1'b1; mdl_mode = 2;
      repeat (3) @(negedge clka);
      wb = wr_addr.size(); db = done_cnt;
      pulse_start(3'b111, 8'h00);
      chk("stale_error_cleared", error, 0);
      repeat (8) @(negedge clka);
      chk("stale_okin_held_low", OKin, 0);
      chk("stale_still_busy", busy, 1);
      chk("stale_no_write", wr_addr.size() - wb, 0);
      man_ok = 1'b0;
      n = 0;
      while (!OKin && n < 10) begin @(negedge clka); n++; end
      chk("stale_rearm_okin", OKin, 1);
      chk("stale_rin_px0", {Rin, Gin, Bin}, 24'h00FF55);
      man_pix = 24'h123456; man_ok = 1'b1;
      n = 0;
      while (OKin && n < 10) begin @(negedge clka); n++; end
      man_ok = 1'b0;
      n = 0;
      while (wr_addr.size() == wb && n < 20) begin @(negedge clka); n++; end
      @(negedge clka);
      got = (wr_din.size() > wb) ? wr_din[wb] : 24'h0;
      chk("stale_first_din", got, 24'h123456);
      mdl_mode = 0;
      n = 0;
      while (!done && n < 3000) begin @(negedge clka); n++; end
      repeat (3) @(negedge clka);
      chk("stale_pass_writes", wr_addr.size() - wb, NPIX);
      chk("stale_pass_done_once", done_cnt - db, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
